ppg_afe_emulator: RTL and testbench
===================================

// Module: ppg_afe_emulator
// PURPOSE
//  Synthesizable analog-front-end stand-in for the PPG controller: consumes LED_RED/LED_IR/LED_DRIVE/
//  DC_Comp/PGA_Gain from the controller and returns the 8-bit ADC sample it reads back.
//  Models a pulsatile photodiode signal per LED channel, DC subtraction, PGA gain, ADC clipping and
//  settling after any setting change. Closes the loop on FPGA/sim without the real analog board.
// PARAMETERS
//  SAMPLE_DIV    1    clock cycles per ADC conversion tick (1 = new sample every CLK)
//  PHASE_INC     66   16-bit phase accumulator step per tick (~1 Hz pulse at 1 kHz tick)
//  RED_DC        80   RED photocurrent DC weight per LED_DRIVE unit
//  RED_AC        4    RED pulsatile amplitude weight
//  IR_DC         100  IR photocurrent DC weight per LED_DRIVE unit
//  IR_AC         6    IR pulsatile amplitude weight
//  DARK_LEVEL    0    raw level when no or both LEDs lit
//  DC_STEP       8    raw units subtracted per DC_Comp LSB
//  SETTLE_CYCLES 4    ticks ADC_valid stays low after any input setting change
// PORTS
//  CLK        in   1  system clock, all logic on posedge
//  rst_n      in   1  synchronous, active-low reset
//  LED_RED    in   1  RED LED enable
//  LED_IR     in   1  IR LED enable
//  LED_DRIVE  in   4  LED current code
//  DC_Comp    in   7  DC compensation code
//  PGA_Gain   in   4  PGA code, linear gain = PGA_Gain+1
//  ADC        out  8  conversion result, unsigned, midscale 128
//  ADC_valid  out  1  high when ADC reflects settled current settings
//  tri_dbg    out  8  current pulse waveform value (debug/bench)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ADC=128, ADC_valid=0, phase=0, tick counter=0, state=SETTLE,
//    settle count=SETTLE_CYCLES, pipeline regs cleared. Reset mid-operation aborts everything likewise.
//  - Tick: counter 0..SAMPLE_DIV-1, tick when counter==SAMPLE_DIV-1; wrap to 0.
//  - Phase: 16-bit acc += PHASE_INC per tick, natural wrap. tri8 = acc[15] ? ~acc[14:7] : acc[14:7].
//  - Channel: RED if LED_RED&~LED_IR; IR if LED_IR&~LED_RED; else DARK.
//  - Stage 1 (tick): raw[12:0] = LED_DRIVE*CH_DC + ((CH_AC*tri8)>>4); DARK -> raw=DARK_LEVEL.
//  - Stage 2: v = $signed(raw) - DC_Comp*DC_STEP (14b signed); y = 128 + v*(PGA_Gain+1) (19b signed);
//    ADC = y<0 ? 0 : y>255 ? 255 : y[7:0]. Latency input->ADC = 2 ticks.
//  - FSM RUN/SETTLE. Setting snapshot = {LED_RED,LED_IR,LED_DRIVE,DC_Comp,PGA_Gain}, registered each CLK.
//    RUN: ADC_valid=1, ADC updates each tick; any snapshot change -> SETTLE, count=SETTLE_CYCLES.
//    SETTLE: ADC_valid=0, ADC holds last value, count-- per tick; change during SETTLE reloads count;
//    count hits 0 -> RUN (pipeline refilled, first valid ADC uses new settings).
//  - Change and tick in same cycle: change wins (enter/restart SETTLE, ADC not updated).
//  - Phase accumulator advances in both states (the pulse does not pause while settling).
// STRUCTURE
//  - Package ppg_afe_pkg: channel enum {CH_DARK,CH_RED,CH_IR}, FSM enum {S_RUN,S_SETTLE},
//    ADC_MID=128, widths RAW_W=13, V_W=14, Y_W=19.
//  - Sub-module ppg_tri_wave: tick-driven phase accumulator + tri8 fold (PHASE_INC param).
//  - Top: tick divider, channel mux, 2-stage arithmetic pipeline, settle FSM.
// TESTING (PHASE_INC=0 freezes tri8=0 unless stated)
//  1 rst_n=0 for 3 CLK -> ADC=128, ADC_valid=0; release -> valid=1 after SETTLE_CYCLES ticks, exactly.
//  2 LED_RED=LED_IR=0, DC_Comp=0, PGA=0 -> ADC=128 constant; both LEDs=1 -> also 128.
//  3 RED, LED_DRIVE=10, DC_Comp=100, PGA=0 -> ADC=128; force tri8=255 (acc=16'h7F80) -> ADC=191.
//  4 RED, LED_DRIVE=10, PGA=0: DC_Comp=127 -> ADC=0 (v=-216); DC_Comp=0 -> ADC=255 (v=800).
//  5 RED, DC_Comp=100, tri8=255: PGA=1 -> ADC=254; PGA=2 -> ADC=255 (clipped).
//  6 Running RED, switch to IR -> ADC_valid low exactly SETTLE_CYCLES ticks, ADC held; second change
//    after 2 ticks -> low period restarts; closed loop with controller converges to DC_Comp giving 120..135.

Source files
------------

// File: rtl/ppg_afe_pkg.sv
// Shared types and constants for the PPG analog-front-end emulator.
//   ch_e       : which photodiode signal the LED enables select
//   state_e    : ADC settle FSM states
//   settings_t : snapshot of every controller input that forces a settle when it changes
//   clip_adc   : saturates the signed gain-stage result to the unsigned 8-bit ADC range
package ppg_afe_pkg;

    typedef enum logic [1:0] {
        CH_DARK = 2'd0,
        CH_RED  = 2'd1,
        CH_IR   = 2'd2
    } ch_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_SETTLE = 1'b1
    } state_e;

    localparam int ADC_MID = 128;
    localparam int RAW_W   = 13;
    localparam int V_W     = 14;
    localparam int Y_W     = 19;

    typedef struct packed {
        logic       led_red;
        logic       led_ir;
        logic [3:0] led_drive;
        logic [6:0] dc_comp;
        logic [3:0] pga_gain;
    } settings_t;

    function automatic logic [7:0] clip_adc(input logic signed [Y_W-1:0] y);
        if (y < 0) begin
            return 8'd0;
        end else if (y > $signed(Y_W'(255))) begin
            return 8'd255;
        end
        return y[7:0];
    endfunction

endpackage

// File: rtl/ppg_tri_wave.sv
// Pulse waveform source: a 16-bit phase accumulator that steps by PHASE_INC on
// every conversion tick and folds into an 8-bit triangle.
//   clk   in   system clock
//   rst_n in   synchronous active-low reset (phase back to 0)
//   tick  in   conversion tick, advances the phase
//   tri8  out  triangle value 0..255
module ppg_tri_wave #(
    parameter logic [15:0] PHASE_INC = 16'd66
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    output logic [7:0] tri8
);

    logic [15:0] acc_q;
    logic [15:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (tick) begin
            acc_d = acc_q + PHASE_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Upper half of the phase circle runs the ramp backwards.
    assign tri8 = acc_q[15] ? ~acc_q[14:7] : acc_q[14:7];

endmodule

// File: rtl/ppg_afe_emulator.sv
// Digital stand-in for the PPG analog front end. Turns the controller's LED and
// AFE settings into the 8-bit ADC sample the controller would read back.
//   CLK        in   system clock
//   rst_n      in   synchronous active-low reset
//   LED_RED    in   RED LED enable
//   LED_IR     in   IR LED enable
//   LED_DRIVE  in   LED current code
//   DC_Comp    in   DC compensation code
//   PGA_Gain   in   PGA code, gain = PGA_Gain+1
//   ADC        out  unsigned conversion result, midscale 128
//   ADC_valid  out  high while ADC reflects settled settings (FSM in S_RUN)
//   tri_dbg    out  current pulse waveform value
module ppg_afe_emulator
    import ppg_afe_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = 1,
    parameter logic [15:0] PHASE_INC     = 16'd66,
    parameter int unsigned RED_DC        = 80,
    parameter int unsigned RED_AC        = 4,
    parameter int unsigned IR_DC         = 100,
    parameter int unsigned IR_AC         = 6,
    parameter int unsigned DARK_LEVEL    = 0,
    parameter int unsigned DC_STEP       = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid,
    output logic [7:0] tri_dbg
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    settings_t        set_now, set_q;
    logic             change;
    ch_e              ch;
    logic [7:0]       tri8;

    logic [RAW_W-1:0] raw_q, raw_d;
    logic [6:0]       dc_q, dc_d;
    logic [3:0]       pga_q, pga_d;

    logic signed [V_W-1:0] v;
    logic signed [Y_W-1:0] v_ext, gain, y;
    logic [7:0]            adc_calc;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       adc_q, adc_d;

    // Conversion tick divider.
    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    ppg_tri_wave #(
        .PHASE_INC (PHASE_INC)
    ) u_tri (
        .clk   (CLK),
        .rst_n (rst_n),
        .tick  (tick),
        .tri8  (tri8)
    );

    // A change is the live inputs differing from last cycle's registered snapshot.
    assign set_now = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain};
    assign change  = (set_now != set_q);

    always_comb begin
        ch = CH_DARK;
        if (LED_RED && !LED_IR) begin
            ch = CH_RED;
        end else if (LED_IR && !LED_RED) begin
            ch = CH_IR;
        end
    end

    // Stage 1: photocurrent. DC_Comp and PGA_Gain travel with the raw value so
    // stage 2 always combines settings from the same tick.
    always_comb begin
        raw_d = raw_q;
        dc_d  = dc_q;
        pga_d = pga_q;
        if (tick) begin
            unique case (ch)
                CH_RED:  raw_d = RAW_W'(LED_DRIVE) * RAW_W'(RED_DC)
                               + ((RAW_W'(RED_AC) * RAW_W'(tri8)) >> 4);
                CH_IR:   raw_d = RAW_W'(LED_DRIVE) * RAW_W'(IR_DC)
                               + ((RAW_W'(IR_AC) * RAW_W'(tri8)) >> 4);
                default: raw_d = RAW_W'(DARK_LEVEL);
            endcase
            dc_d  = DC_Comp;
            pga_d = PGA_Gain;
        end
    end

    // Stage 2: DC subtraction, gain around midscale, clip.
    always_comb begin
        v        = $signed(V_W'(raw_q)) - $signed(V_W'(dc_q) * V_W'(DC_STEP));
        v_ext    = {{(Y_W - V_W){v[V_W-1]}}, v};
        gain     = $signed(Y_W'(pga_q) + Y_W'(1));
        y        = $signed(Y_W'(ADC_MID)) + v_ext * gain;
        adc_calc = clip_adc(y);
    end

    // Settle FSM. A setting change always wins over a tick. The tick that ends
    // SETTLE also loads ADC, so the first valid sample already uses the new
    // settings (the pipeline refills well inside the settle window).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adc_d   = adc_q;
        if (change) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_INIT;
        end else if (tick) begin
            unique case (state_q)
                S_RUN: begin
                    adc_d = adc_calc;
                end
                S_SETTLE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        adc_d   = adc_calc;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            div_q   <= '0;
            set_q   <= '0;
            raw_q   <= '0;
            dc_q    <= '0;
            pga_q   <= '0;
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_INIT;
            adc_q   <= 8'(ADC_MID);
        end else begin
            div_q   <= div_d;
            set_q   <= set_now;
            raw_q   <= raw_d;
            dc_q    <= dc_d;
            pga_q   <= pga_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adc_q   <= adc_d;
        end
    end

    assign ADC       = adc_q;
    assign ADC_valid = (state_q == S_RUN);
    assign tri_dbg   = tri8;

endmodule

// File: tb/tb_ppg_afe_emulator.sv
// Bench for ppg_afe_emulator. dut runs with a frozen pulse (PHASE_INC=0);
// dut_p shares every input but steps its phase by 1 per tick, so the bench can
// wait until its own phase model sits where the triangle is at its peak of 255.
module tb_ppg_afe_emulator;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       led_red = 1'b0;
    logic       led_ir = 1'b0;
    logic [3:0] led_drive = 4'd0;
    logic [6:0] dc_comp = 7'd0;
    logic [3:0] pga_gain = 4'd0;

    logic [7:0] adc, tri_o, adc_p, tri_p;
    logic       valid, valid_p;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [15:0] acc_m;

    // ---------------- clock / reset / phase model ----------------
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!rst_n) acc_m <= 16'd0;
        else        acc_m <= acc_m + 16'd1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    ppg_afe_emulator #(.SAMPLE_DIV(1), .PHASE_INC(16'd0)) dut (
        .CLK(CLK), .rst_n(rst_n), .LED_RED(led_red), .LED_IR(led_ir),
        .LED_DRIVE(led_drive), .DC_Comp(dc_comp), .PGA_Gain(pga_gain),
        .ADC(adc), .ADC_valid(valid), .tri_dbg(tri_o)
    );

    ppg_afe_emulator #(.SAMPLE_DIV(1), .PHASE_INC(16'd1)) dut_p (
        .CLK(CLK), .rst_n(rst_n), .LED_RED(led_red), .LED_IR(led_ir),
        .LED_DRIVE(led_drive), .DC_Comp(dc_comp), .PGA_Gain(pga_gain),
        .ADC(adc_p), .ADC_valid(valid_p), .tri_dbg(tri_p)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_adc(input logic red, input logic ir, input logic [3:0] drive,
                                             input logic [6:0] dc, input logic [3:0] pga, input logic [7:0] t8);
        int raw, v, y;
        if (red && !ir)      raw = int'(drive) * 80 + (4 * int'(t8)) / 16;
        else if (ir && !red) raw = int'(drive) * 100 + (6 * int'(t8)) / 16;
        else                 raw = 0;
        v = raw - int'(dc) * 8;
        y = 128 + v * (int'(pga) + 1);
        if (y < 0)   return 8'd0;
        if (y > 255) return 8'd255;
        return y[7:0];
    endfunction

    function automatic logic [7:0] tri_model(input logic [15:0] a);
        return a[15] ? ~a[14:7] : a[14:7];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_settings(input logic red, input logic ir, input logic [3:0] drive,
                                  input logic [6:0] dc, input logic [3:0] pga);
        led_red = red; led_ir = ir; led_drive = drive; dc_comp = dc; pga_gain = pga;
    endtask

    // Returns the number of falling edges until ADC_valid is seen high, -1 on timeout.
    task automatic wait_valid(output int cycles);
        int i;
        cycles = -1;
        i = 0;
        while (cycles < 0 && i < 64) begin
            @(negedge CLK);
            i++;
            if (valid === 1'b1) cycles = i;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic e;
        rst_n = 1'b0;
        drive_settings(1'b0, 1'b0, 4'd0, 7'd0, 4'd0);
        repeat (3) @(negedge CLK);
        n_vec++;
        if (adc !== 8'd128) begin n_err++; $display("FAIL reset_adc: got %0d expected 128", adc); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            e = (i == 4);
            n_vec++;
            if (valid !== e) begin n_err++; $display("FAIL release_valid_t%0d: got %b expected %b", i, valid, e); end
        end
        exp_q.push_back(8'd128);
        n_vec++;
        if (adc !== exp_q[0]) begin n_err++; $display("FAIL release_adc: got %0d expected %0d", adc, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_dark();
        int cyc;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'd128);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_vec++;
            if (adc !== e || valid !== 1'b1) begin
                n_err++; $display("FAIL dark_off_%0d: got %0d/%b expected %0d/1", i, adc, valid, e);
            end
        end
        drive_settings(1'b1, 1'b1, 4'd7, 7'd0, 4'd3);
        exp_q.push_back(model_adc(1'b1, 1'b1, 4'd7, 7'd0, 4'd3, 8'd0));
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (cyc < 0 || adc !== e) begin n_err++; $display("FAIL dark_both: got %0d (wait %0d) expected %0d", adc, cyc, e); end
    endtask

    task automatic test_dc_clip();
        int cyc;
        logic [7:0] e;
        logic [6:0] dcs [3];
        logic [7:0] exps [3];
        dcs[0] = 7'd100; exps[0] = 8'd128;
        dcs[1] = 7'd127; exps[1] = 8'd0;
        dcs[2] = 7'd0;   exps[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            drive_settings(1'b1, 1'b0, 4'd10, dcs[i], 4'd0);
            exp_q.push_back(exps[i]);
            wait_valid(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (cyc < 0 || adc !== e) begin n_err++; $display("FAIL dc_clip_dc%0d: got %0d (wait %0d) expected %0d", dcs[i], adc, cyc, e); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, low;
        logic held_ok, done;
        logic [7:0] e;
        drive_settings(1'b1, 1'b0, 4'd10, 7'd100, 4'd0);
        exp_q.push_back(8'd128);
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (cyc < 0 || adc !== e) begin n_err++; $display("FAIL b2b_red: got %0d expected %0d", adc, e); end

        // RED -> IR: valid low for exactly four ticks, ADC held.
        drive_settings(1'b0, 1'b1, 4'd10, 7'd100, 4'd0);
        exp_q.push_back(8'd255);
        low = 0; held_ok = 1'b1; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) done = 1'b1;
            else begin low++; if (adc !== 8'd128) held_ok = 1'b0; end
        end
        n_vec++;
        if (low != 4) begin n_err++; $display("FAIL settle_len: got %0d low ticks expected 4", low); end
        n_vec++;
        if (!held_ok) begin n_err++; $display("FAIL settle_hold: got changing ADC expected held 128"); end
        e = exp_q.pop_front();
        n_vec++;
        if (adc !== e) begin n_err++; $display("FAIL b2b_ir: got %0d expected %0d", adc, e); end

        // Change, then change again two ticks later: low period restarts.
        drive_settings(1'b1, 1'b0, 4'd10, 7'd110, 4'd0);
        repeat (2) @(negedge CLK);
        n_vec++;
        if (valid !== 1'b0 || adc !== 8'd255) begin n_err++; $display("FAIL restart_pre: got %0d/%b expected 255/0", adc, valid); end
        drive_settings(1'b1, 1'b0, 4'd10, 7'd105, 4'd0);
        exp_q.push_back(8'd88);
        low = 0; held_ok = 1'b1; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) done = 1'b1;
            else begin low++; if (adc !== 8'd255) held_ok = 1'b0; end
        end
        n_vec++;
        if (low != 4) begin n_err++; $display("FAIL restart_len: got %0d low ticks expected 4", low); end
        n_vec++;
        if (!held_ok) begin n_err++; $display("FAIL restart_hold: got changing ADC expected held 255"); end
        e = exp_q.pop_front();
        n_vec++;
        if (adc !== e) begin n_err++; $display("FAIL restart_adc: got %0d expected %0d", adc, e); end
    endtask

    task automatic test_random();
        int cyc;
        logic r, ir;
        logic [3:0] d, g;
        logic [6:0] c;
        logic [7:0] e;
        for (int i = 0; i < 10; i++) begin
            r  = 1'($urandom_range(0, 1));
            ir = 1'($urandom_range(0, 1));
            d  = 4'($urandom_range(0, 15));
            c  = 7'($urandom_range(0, 127));
            g  = 4'($urandom_range(0, 15));
            drive_settings(r, ir, d, c, g);
            exp_q.push_back(model_adc(r, ir, d, c, g, 8'd0));
            wait_valid(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (cyc < 0 || adc !== e) begin
                n_err++; $display("FAIL random_%0d r%0b i%0b d%0d c%0d g%0d: got %0d expected %0d", i, r, ir, d, c, g, adc, e);
            end
        end
    endtask

    task automatic test_closed_loop();
        int cyc, iter;
        logic conv;
        logic [6:0] dc, dc_exp;
        dc_exp = 7'd0;
        while (dc_exp != 7'd127 && model_adc(1'b1, 1'b0, 4'd10, dc_exp, 4'd0, 8'd0) > 8'd135) dc_exp++;
        dc = 7'd0; conv = 1'b0; iter = 0;
        drive_settings(1'b1, 1'b0, 4'd10, dc, 4'd0);
        exp_q.push_back(model_adc(1'b1, 1'b0, 4'd10, dc_exp, 4'd0, 8'd0));
        while (!conv && iter < 200) begin
            wait_valid(cyc);
            if (cyc < 0) iter = 200;
            else if (adc > 8'd135 && dc != 7'd127) dc++;
            else if (adc < 8'd120 && dc != 7'd0) dc--;
            else conv = 1'b1;
            if (!conv) drive_settings(1'b1, 1'b0, 4'd10, dc, 4'd0);
            iter++;
        end
        n_vec++;
        if (!conv || adc < 8'd120 || adc > 8'd135) begin n_err++; $display("FAIL loop_range: got %0d expected 120..135", adc); end
        n_vec++;
        if (dc != dc_exp) begin n_err++; $display("FAIL loop_dc: got %0d expected %0d", dc, dc_exp); end
        n_vec++;
        if (adc !== exp_q[0]) begin n_err++; $display("FAIL loop_adc: got %0d expected %0d", adc, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_tri_peak();
        int cyc, guard;
        logic [7:0] e;
        logic [3:0] gains [3];
        logic [7:0] exps [3];
        guard = 0;
        while (acc_m < 16'h7F90 && guard < 70000) begin @(negedge CLK); guard++; end
        n_vec++;
        if (tri_p !== tri_model(acc_m)) begin n_err++; $display("FAIL tri_phase: got %0d expected %0d", tri_p, tri_model(acc_m)); end
        n_vec++;
        if (tri_o !== 8'd0) begin n_err++; $display("FAIL tri_frozen: got %0d expected 0", tri_o); end
        gains[0] = 4'd0; exps[0] = 8'd191;
        gains[1] = 4'd1; exps[1] = 8'd254;
        gains[2] = 4'd2; exps[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            drive_settings(1'b1, 1'b0, 4'd10, 7'd100, gains[i]);
            exp_q.push_back(exps[i]);
            wait_valid(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (cyc < 0 || adc_p !== e) begin n_err++; $display("FAIL tri_peak_pga%0d: got %0d expected %0d", gains[i], adc_p, e); end
            n_vec++;
            if (adc !== 8'd128) begin n_err++; $display("FAIL tri_flat_pga%0d: got %0d expected 128", gains[i], adc); end
        end
        n_vec++;
        if (tri_p !== 8'd255) begin n_err++; $display("FAIL tri_peak_wave: got %0d expected 255", tri_p); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        drive_settings(1'b1, 1'b0, 4'd10, 7'd0, 4'd0);
        wait_valid(cyc);
        n_vec++;
        if (cyc < 0 || adc !== 8'd255) begin n_err++; $display("FAIL mid_pre: got %0d expected 255", adc); end
        rst_n = 1'b0;
        drive_settings(1'b0, 1'b0, 4'd0, 7'd0, 4'd0);
        @(negedge CLK);
        n_vec++;
        if (adc !== 8'd128 || valid !== 1'b0) begin n_err++; $display("FAIL mid_reset: got %0d/%b expected 128/0", adc, valid); end
        @(negedge CLK);
        rst_n = 1'b1;
        exp_q.push_back(8'd128);
        wait_valid(cyc);
        n_vec++;
        if (cyc != 4) begin n_err++; $display("FAIL mid_release_len: got %0d expected 4", cyc); end
        n_vec++;
        if (adc !== exp_q[0]) begin n_err++; $display("FAIL mid_release_adc: got %0d expected %0d", adc, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_dark();
        test_dc_clip();
        test_back_to_back();
        test_random();
        test_closed_loop();
        test_tri_peak();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
